// File: rtl/inst_fetch.sv
// inst_fetch: PC generator with a DEPTH-entry {pc, inst} prefetch queue and branch flush
module inst_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_ONE = 1;
  localparam logic [AW-1:0] P_ONE = 1;
  logic [31:0] pc;
  logic [31:0] pcs [DEPTH];
  logic [31:0] insts [DEPTH];
  logic run;
  logic [AW:0] count;
  logic [AW-1:0] rd, wr;
  logic valid, pop, push;
  // count is a power of two at most, so its top bit alone flags a full queue
  always_comb begin
    valid = |count;
    pop = valid & ~stall_i;
    push = run & ~branch_flag_i & (~count[AW] | pop);
  end
  assign rom_ce_o = push;
  assign rom_addr_o = pc;
  assign inst_valid_o = valid;
  assign inst_o = valid ? insts[rd] : 32'h0;
  assign inst_pc_o = valid ? pcs[rd] : 32'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      run <= 1'b0;
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      run <= 1'b1;
      if (branch_flag_i) begin
        pc <= {branch_target_i[31:2], 2'b00};
        count <= '0;
        rd <= '0;
        wr <= '0;
      end else begin
        if (push) begin
          pc <= pc + 32'd4;
          wr <= wr + P_ONE;
        end
        if (pop) rd <= rd + P_ONE;
        count <= (push & ~pop) ? count + C_ONE : (pop & ~push) ? count - C_ONE : count;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pcs[wr] <= pc;
      insts[wr] <= rom_data_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven directed check of inst_fetch with a hand-written async reset sequence
module tb_inst_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, rst = 1;
  logic [31:0] rom_addr, rom_data, tgt, inst, inst_pc;
  logic rom_ce, stall, br, valid;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign rom_data = rom_addr ^ K;
  inst_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .rom_data_i(rom_data),
    .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(valid)
  );
  typedef struct {
    logic s; logic b; logic [31:0] t;
    logic ce; logic [31:0] addr; logic v; logic [31:0] pc;
  } vec_t;
  vec_t v [18];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic chk_out(input string n, input logic ce, input logic [31:0] addr, input logic vl, input logic [31:0] pc);
    chk({n, " ce"}, {31'h0, rom_ce}, {31'h0, ce});
    chk({n, " addr"}, rom_addr, addr);
    chk({n, " valid"}, {31'h0, valid}, {31'h0, vl});
    chk({n, " pc"}, inst_pc, vl ? pc : 32'h0);
    chk({n, " inst"}, inst, vl ? pc ^ K : 32'h0);
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    v[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    v[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    v[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0};
    v[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h0};
    v[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h0};
    v[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h0};
    v[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h4};
    v[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'h8};
    v[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 32'hC};
    v[10] = '{1'b1, 1'b1, 32'h103,      1'b0, 32'h1C,       1'b1, 32'hC};
    v[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0};
    v[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100};
    v[13] = '{1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h108,      1'b1, 32'h100};
    v[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 32'h0};
    v[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFFFFFC};
    v[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    v[17] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h4};
    stall = 0; br = 0; tgt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      stall = v[i].s; br = v[i].b; tgt = v[i].t;
      #1;
      chk_out($sformatf("row%0d", i), v[i].ce, v[i].addr, v[i].v, v[i].pc);
      @(negedge clk);
    end
    br = 0; tgt = 0;
    #1;
    chk_out("pre_rst", 1'b1, 32'hC, 1'b1, 32'h4);
    rst = 1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    stall = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk_out("restart0", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("restart1", 1'b1, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("restart2", 1'b1, 32'h4, 1'b1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rom_addr_o  output  32  instruction ROM address (fetch PC).
REQ-006 SHALL have port rom_ce_o  output  1  ROM chip enable; fetch occurs in every cycle it is high.
REQ-007 SHALL have port rom_data_i  input  32  ROM word, combinational, valid in the same cycle as rom_addr_o while rom_ce_o=1.
REQ-008 SHALL have port stall_i  input  1  downstream (decode) not accepting this cycle.
REQ-009 SHALL have port branch_flag_i  input  1  redirect request, single-cycle pulse.
REQ-010 SHALL have port branch_target_i  input  32  redirect address, valid with branch_flag_i.
REQ-011 SHALL have port inst_o  output  32  instruction at queue head.
REQ-012 SHALL have port inst_pc_o  output  32  address of inst_o.
REQ-013 SHALL have port inst_valid_o  output  1  queue head valid.

Function
REQ-014 SHALL hold a fetch PC register, a registered run flag, and a FIFO of DEPTH {pc, inst} entries with a count of 0..DEPTH.
REQ-015 SHALL set run flag to 1 on the first rising edge with rst low; rom_ce_o SHALL be 0 while the run flag is 0.
REQ-016 Pop SHALL occur when inst_valid_o=1 and stall_i=0.
REQ-017 rom_ce_o SHALL equal run & ~branch_flag_i & (count<DEPTH | pop), combinationally.
REQ-018 rom_addr_o SHALL equal the fetch PC register.
REQ-019 When rom_ce_o=1, on the clock edge: SHALL push {rom_addr_o, rom_data_i} at the tail and set fetch PC to fetch PC+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push into a full queue SHALL only occur with a same-cycle pop.
REQ-021 When branch_flag_i=1: SHALL, on the edge, empty the queue (count=0), discard any pop, set fetch PC to {branch_target_i[31:2], 2'b00}; branch has priority over stall_i, push and pop.
REQ-022 inst_valid_o SHALL be 1 exactly when count>0; inst_o/inst_pc_o SHALL show the head entry, and 32'h0 when count=0.
REQ-023 Outputs SHALL hold stable while inst_valid_o=1 and stall_i=1 (no branch).
REQ-024 Instructions SHALL reach inst_o in fetch order, one cycle after their fetch at the earliest; no entry SHALL be lost or duplicated outside a branch flush.
REQ-025 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 While rst=1: fetch PC=RESET_PC, run=0, count=0, pointers=0, rom_ce_o=0, rom_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-027 Assertion of rst mid-operation SHALL clear state immediately (asynchronously), discarding queue contents and any pending branch.
REQ-028 Queue storage contents need not be reset; outputs SHALL not depend on them when count=0.

Verification
REQ-029 Release rst, stall_i=0, ROM word=address -> rom_ce_o=1 from cycle 1; inst_pc_o/inst_o = 0,4,8,... one per cycle from cycle 2.
REQ-030 stall_i=1 held, DEPTH=4 -> after 4 fetches (pcs 0,4,8,C) rom_ce_o=0, rom_addr_o=32'h10, inst_o stays at pc 0; release stall -> pcs 4,8,C,10 appear in order, no gap.
REQ-031 Full queue with stall_i=0 -> push and pop same cycle, rom_ce_o stays 1, count stays 4.
REQ-032 branch_flag_i=1, target=32'h0000_0103, queue holding 3 entries, stall_i=1 -> next cycle inst_valid_o=0, rom_addr_o=32'h100; following cycle inst_pc_o=32'h100.
REQ-033 Fetch PC set to 32'hFFFF_FFFC via branch -> fetches FFFF_FFFC then 0000_0000.
REQ-034 Assert rst asynchronously between edges with 2 valid entries -> inst_valid_o and rom_ce_o drop to 0 before the next edge; after release fetch restarts at RESET_PC.
